// File: rtl/tlb_op_ctrl.sv
// TLB operation controller: sequences TLBP/TLBR/TLBWI/TLBWR through IDLE/EXEC/DONE
// and maintains the CP0 Random register used for random replacement.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    input  logic [1:0]    op_type,
    output logic          op_ready,
    output logic          op_done,
    input  logic [IW-1:0] cp0_index,
    input  logic [IW-1:0] cp0_wired,
    input  logic [31:0]   cp0_entryhi,
    output logic [18:0]   tlb_s_vpn2,
    output logic [7:0]    tlb_s_asid,
    input  logic          tlb_s_found,
    input  logic [IW-1:0] tlb_s_index,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic [IW-1:0] tlb_r_index,
    output logic          cp0_index_we,
    output logic [31:0]   cp0_index_wdata,
    output logic          cp0_tlbr_we,
    output logic [IW-1:0] random_index
);

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    localparam logic [IW-1:0] MAX_IDX = IW'(TLBNUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t        state;
    logic [1:0]    op_q;
    logic [IW-1:0] index_q;
    logic [18:0]   vpn2_q;
    logic [7:0]    asid_q;

    logic          unused_entryhi_bits;
    assign unused_entryhi_bits = ^cp0_entryhi[12:8];

    assign tlb_s_vpn2  = vpn2_q;
    assign tlb_s_asid  = asid_q;
    assign tlb_r_index = index_q;

    // Operands are captured at accept so later CP0 writes cannot disturb the op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            op_ready        <= 1'b1;
            op_done         <= 1'b0;
            tlb_we          <= 1'b0;
            tlb_w_index     <= '0;
            cp0_index_we    <= 1'b0;
            cp0_index_wdata <= '0;
            cp0_tlbr_we     <= 1'b0;
            op_q            <= OP_TLBP;
            index_q         <= '0;
            vpn2_q          <= '0;
            asid_q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        state       <= EXEC;
                        op_ready    <= 1'b0;
                        op_q        <= op_type;
                        index_q     <= cp0_index;
                        vpn2_q      <= cp0_entryhi[31:13];
                        asid_q      <= cp0_entryhi[7:0];
                        tlb_we      <= (op_type == OP_TLBWI) || (op_type == OP_TLBWR);
                        tlb_w_index <= (op_type == OP_TLBWR) ? random_index : cp0_index;
                    end
                end
                EXEC: begin
                    state           <= DONE;
                    tlb_we          <= 1'b0;
                    op_done         <= 1'b1;
                    cp0_index_we    <= (op_q == OP_TLBP);
                    cp0_tlbr_we     <= (op_q == OP_TLBR);
                    cp0_index_wdata <= {~tlb_s_found, {(31 - IW){1'b0}},
                                        tlb_s_found ? tlb_s_index : {IW{1'b0}}};
                end
                DONE: begin
                    state        <= IDLE;
                    op_ready     <= 1'b1;
                    op_done      <= 1'b0;
                    cp0_index_we <= 1'b0;
                    cp0_tlbr_we  <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    op_ready     <= 1'b1;
                    op_done      <= 1'b0;
                    tlb_we       <= 1'b0;
                    cp0_index_we <= 1'b0;
                    cp0_tlbr_we  <= 1'b0;
                end
            endcase
        end
    end

    // Random wraps back to the top once it reaches Wired; a Wired at or above the top pins it there.
    always_ff @(posedge clk) begin
        if (reset) begin
            random_index <= MAX_IDX;
        end else if ((cp0_wired >= MAX_IDX) || (random_index <= cp0_wired)) begin
            random_index <= MAX_IDX;
        end else begin
            random_index <= random_index - 1'b1;
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: directed literal scenarios followed by randomized traffic,
// all checked every cycle against a latency-based behavioural model.
module tb_tlb_op_ctrl;

    localparam int TLBNUM = 16;
    localparam int IW     = $clog2(TLBNUM);
    localparam int MAXI   = TLBNUM - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic [1:0]    op_type;
    logic          op_ready;
    logic          op_done;
    logic [IW-1:0] cp0_index;
    logic [IW-1:0] cp0_wired;
    logic [31:0]   cp0_entryhi;
    logic [18:0]   tlb_s_vpn2;
    logic [7:0]    tlb_s_asid;
    logic          tlb_s_found;
    logic [IW-1:0] tlb_s_index;
    logic          tlb_we;
    logic [IW-1:0] tlb_w_index;
    logic [IW-1:0] tlb_r_index;
    logic          cp0_index_we;
    logic [31:0]   cp0_index_wdata;
    logic          cp0_tlbr_we;
    logic [IW-1:0] random_index;

    int checks = 0;
    int errors = 0;

    tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk            (clk),
        .reset          (reset),
        .op_valid       (op_valid),
        .op_type        (op_type),
        .op_ready       (op_ready),
        .op_done        (op_done),
        .cp0_index      (cp0_index),
        .cp0_wired      (cp0_wired),
        .cp0_entryhi    (cp0_entryhi),
        .tlb_s_vpn2     (tlb_s_vpn2),
        .tlb_s_asid     (tlb_s_asid),
        .tlb_s_found    (tlb_s_found),
        .tlb_s_index    (tlb_s_index),
        .tlb_we         (tlb_we),
        .tlb_w_index    (tlb_w_index),
        .tlb_r_index    (tlb_r_index),
        .cp0_index_we   (cp0_index_we),
        .cp0_index_wdata(cp0_index_wdata),
        .cp0_tlbr_we    (cp0_tlbr_we),
        .random_index   (random_index)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] t, input logic [IW-1:0] idx,
                                 input logic [31:0] ehi, input logic f, input logic [IW-1:0] sidx);
        op_valid    = v;
        op_type     = t;
        cp0_index   = idx;
        cp0_entryhi = ehi;
        tlb_s_found = f;
        tlb_s_index = sidx;
    endtask

    // Model: an op accepted at edge A shows its execute effects after edge A+1,
    // its completion effects after A+2, and the controller is free again after A+2.
    int          cyc = 0;
    bit          m_valid = 0;
    int          m_acc = -10;
    int          m_rand = MAXI;
    int          m_wr_rand = 0;
    logic [1:0]  m_op = 0;
    logic [IW-1:0] m_idx = 0;
    logic [18:0] m_vpn = 0;
    logic [7:0]  m_asid = 0;
    logic        m_found = 0;
    logic [IW-1:0] m_sidx = 0;

    always @(posedge clk) begin
        int  phase;
        bit  busy;
        bit  e_we;
        bit  e_iwe;
        bit  e_rwe;
        logic [31:0] e_wdata;
        cyc++;
        if (reset) begin
            m_valid   = 1;
            m_acc     = -10;
            m_rand    = MAXI;
            m_wr_rand = 0;
            m_op      = 0;
            m_idx     = 0;
            m_vpn     = 0;
            m_asid    = 0;
        end else if (m_valid) begin
            busy = (cyc == m_acc + 1) || (cyc == m_acc + 2);
            if (cyc == m_acc + 1) begin
                m_found = tlb_s_found;
                m_sidx  = tlb_s_index;
            end
            if (!busy && op_valid) begin
                m_acc     = cyc;
                m_op      = op_type;
                m_idx     = cp0_index;
                m_vpn     = cp0_entryhi[31:13];
                m_asid    = cp0_entryhi[7:0];
                m_wr_rand = m_rand;
            end
            if (int'(cp0_wired) >= MAXI || m_rand <= int'(cp0_wired)) m_rand = MAXI;
            else m_rand = m_rand - 1;
        end
        #1;
        if (m_valid) begin
            phase   = cyc - m_acc;
            e_we    = (phase == 0) && m_op[1];
            e_iwe   = (phase == 1) && (m_op == 2'b00);
            e_rwe   = (phase == 1) && (m_op == 2'b01);
            e_wdata = m_found ? 32'(m_sidx) : 32'h8000_0000;
            checkOutput("op_ready", 32'(op_ready), 32'(!(phase == 0 || phase == 1)));
            checkOutput("op_done", 32'(op_done), 32'(phase == 1));
            checkOutput("tlb_we", 32'(tlb_we), 32'(e_we));
            checkOutput("cp0_index_we", 32'(cp0_index_we), 32'(e_iwe));
            checkOutput("cp0_tlbr_we", 32'(cp0_tlbr_we), 32'(e_rwe));
            checkOutput("random_index", 32'(random_index), 32'(m_rand));
            checkOutput("tlb_s_vpn2", 32'(tlb_s_vpn2), 32'(m_vpn));
            checkOutput("tlb_s_asid", 32'(tlb_s_asid), 32'(m_asid));
            if (e_we)
                checkOutput("tlb_w_index", 32'(tlb_w_index),
                            (m_op == 2'b10) ? 32'(m_idx) : 32'(m_wr_rand));
            if (e_iwe)
                checkOutput("cp0_index_wdata", cp0_index_wdata, e_wdata);
            if ((phase == 0 || phase == 1) && m_op == 2'b01)
                checkOutput("tlb_r_index", 32'(tlb_r_index), 32'(m_idx));
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int we_cnt;
        int done_cnt;
        reset     = 1'b1;
        cp0_wired = 4'd4;
        applyStimulus(1'b0, 2'b00, 4'd0, 32'h0, 1'b0, 4'd0);

        // Reset state and Random countdown with Wired = 4
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_op_ready", 32'(op_ready), 32'd1);
        checkOutput("rst_op_done", 32'(op_done), 32'd0);
        checkOutput("rst_tlb_we", 32'(tlb_we), 32'd0);
        checkOutput("rst_random", 32'(random_index), 32'd15);
        checkOutput("rst_vpn2", 32'(tlb_s_vpn2), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #2;
            checkOutput("rand_seq", 32'(random_index), (i <= 11) ? 32'(15 - i) : 32'd15);
        end

        // TLBWI to entry 5
        @(negedge clk);
        applyStimulus(1'b1, 2'b10, 4'd5, 32'h0, 1'b0, 4'd0);
        @(posedge clk); #2;
        checkOutput("wi_we_t1", 32'(tlb_we), 32'd1);
        checkOutput("wi_widx_t1", 32'(tlb_w_index), 32'd5);
        @(negedge clk);
        op_valid = 1'b0;
        @(posedge clk); #2;
        checkOutput("wi_we_t2", 32'(tlb_we), 32'd0);
        checkOutput("wi_done_t2", 32'(op_done), 32'd1);
        @(posedge clk); #2;
        checkOutput("wi_ready_t3", 32'(op_ready), 32'd1);
        checkOutput("wi_done_t3", 32'(op_done), 32'd0);

        // TLBP hit on entry 9, then miss
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, 2'b00, 4'd2, {19'h12345, 5'd0, 8'h0A}, (k == 0), 4'd9);
            @(posedge clk); #2;
            checkOutput("p_vpn2", 32'(tlb_s_vpn2), 32'h12345);
            checkOutput("p_asid", 32'(tlb_s_asid), 32'h0A);
            @(negedge clk);
            op_valid = 1'b0;
            @(posedge clk); #2;
            checkOutput("p_index_we", 32'(cp0_index_we), 32'd1);
            checkOutput("p_wdata", cp0_index_wdata, (k == 0) ? 32'h0000_0009 : 32'h8000_0000);
            @(posedge clk);
        end

        // TLBR entry 3 with Index rewritten while in flight
        @(negedge clk);
        applyStimulus(1'b1, 2'b01, 4'd3, 32'h0, 1'b0, 4'd0);
        @(posedge clk); #2;
        checkOutput("r_ridx_t1", 32'(tlb_r_index), 32'd3);
        checkOutput("r_tlbr_we_t1", 32'(cp0_tlbr_we), 32'd0);
        @(negedge clk);
        op_valid  = 1'b0;
        cp0_index = 4'd12;
        @(posedge clk); #2;
        checkOutput("r_ridx_t2", 32'(tlb_r_index), 32'd3);
        checkOutput("r_tlbr_we_t2", 32'(cp0_tlbr_we), 32'd1);
        @(posedge clk); #2;
        checkOutput("r_tlbr_we_t3", 32'(cp0_tlbr_we), 32'd0);

        // TLBWR accepted while Random = 7
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 2'b11, 4'd1, 32'h0, 1'b0, 4'd0);
        @(posedge clk); #2;
        checkOutput("wr_we", 32'(tlb_we), 32'd1);
        checkOutput("wr_widx", 32'(tlb_w_index), 32'd7);
        @(negedge clk);
        op_valid = 1'b0;
        repeat (2) @(posedge clk);

        // op_valid held high: one accept every third cycle
        @(negedge clk);
        applyStimulus(1'b1, 2'b10, 4'd6, 32'h0, 1'b0, 4'd0);
        we_cnt   = 0;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #2;
            if (tlb_we) we_cnt++;
            if (op_done) done_cnt++;
        end
        checkOutput("hold_we_count", 32'(we_cnt), 32'd10);
        checkOutput("hold_done_count", 32'(done_cnt), 32'd10);
        @(negedge clk);
        op_valid = 1'b0;

        // Reset while TLBWI is executing
        @(negedge clk);
        applyStimulus(1'b1, 2'b10, 4'd8, 32'h0, 1'b0, 4'd0);
        @(posedge clk); #2;
        checkOutput("abort_exec_we", 32'(tlb_we), 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #2;
        checkOutput("abort_we", 32'(tlb_we), 32'd0);
        checkOutput("abort_ready", 32'(op_ready), 32'd1);
        checkOutput("abort_done", 32'(op_done), 32'd0);
        checkOutput("abort_random", 32'(random_index), 32'd15);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            checkOutput("abort_no_done", 32'(op_done), 32'd0);
            checkOutput("abort_no_we", 32'(tlb_we), 32'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            applyStimulus(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
                          IW'($urandom_range(0, MAXI)), $urandom, ($urandom_range(0, 1) == 1),
                          IW'($urandom_range(0, MAXI)));
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 63) == 0) cp0_wired = IW'($urandom_range(0, MAXI));
        end

        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 4'd0, 32'h0, 1'b0, 4'd0);
        reset = 1'b0;
        @(posedge clk); #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
